data_mem_ctrl: RTL

Request-side controller for the register-file-style data memory: accepts read, write and clear commands over a valid/ready handshake and drives the memory's write port and first read port. It owns all sequencing, including a multi-cycle clear sweep, and returns one response per command. The controller changes its outputs on the rising edge of `clk`. The memory writes on the falling edge, so every write is committed mid-cycle.

---
 rtl/data_mem_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// Request-side sequencer for the register-file data memory: read, write and
// multi-cycle clear commands over valid/ready, one response per command.
module data_mem_ctrl #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              w_flag,
   output logic [ADDR_W-1:0] w_add,
   output logic [DATA_W-1:0] w_data,
   output logic [ADDR_W-1:0] r_add1,
   input  logic [DATA_W-1:0] r_data1,
   output logic              mem_update_flag
);
   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic [2:0] {IDLE, WRITE, READ, CLEAR, RESP} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr_q, cnt, w_add_q;
   logic [DATA_W-1:0] wdata_q, w_data_q;
   logic              clr_last;

   assign clr_last = (cnt == ADDR_W'(DEPTH - 1));
   assign r_add1   = addr_q;
   assign w_add    = w_add_q;
   assign w_data   = w_data_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // w_flag is decoded from state so reset kills it without waiting for an edge.
   always_comb begin
      state_nxt       = state;
      req_ready       = 1'b0;
      rsp_valid       = 1'b0;
      w_flag          = 1'b0;
      mem_update_flag = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               case (req_op)
                  2'b00:   state_nxt = READ;
                  2'b01:   state_nxt = WRITE;
                  2'b10:   state_nxt = CLEAR;
                  default: state_nxt = RESP;
               endcase
            end
         end
         WRITE: begin
            w_flag          = 1'b1;
            mem_update_flag = 1'b1;
            state_nxt       = RESP;
         end
         READ: state_nxt = RESP;
         CLEAR: begin
            w_flag = 1'b1;
            if (clr_last) begin
               mem_update_flag = 1'b1;
               state_nxt       = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         cnt      <= '0;
         w_add_q  <= '0;
         w_data_q <= '0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               addr_q  <= req_addr;
               wdata_q <= req_wdata;
               cnt     <= '0;
               rsp_err <= (req_op == 2'b11);
               case (req_op)
                  2'b01: begin
                     w_add_q  <= req_addr;
                     w_data_q <= req_wdata;
                  end
                  2'b10: begin
                     w_add_q  <= '0;
                     w_data_q <= '0;
                  end
                  2'b11:   rsp_data <= '0;
                  default: ;
               endcase
            end
            WRITE: rsp_data <= wdata_q;
            READ:  rsp_data <= r_data1;
            CLEAR: begin
               // counter wraps on the last step; the compare decides the exit
               cnt <= cnt + 1'b1;
               if (clr_last) rsp_data <= '0;
               else          w_add_q  <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule
